// File: rtl/lut_target_prog_if.sv
// Bus bundle for lut_target_prog: streaming loader, patch write port and read channels.
// With LUT_PARITY_EN defined, also carries par_inject and par_err.
interface lut_target_prog_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned NRD    = 2
);
    logic                    load_start;
    logic                    load_valid;
    logic [DATA_W-1:0]       load_data;
    logic                    load_ready;
    logic                    busy;
    logic                    table_valid;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_index;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_drop;
    logic [NRD*IDX_W-1:0]    rd_index;
    logic [NRD*OUT_W-1:0]    rd_out;
`ifdef LUT_PARITY_EN
    logic                    par_inject;
    logic [NRD-1:0]          par_err;
`endif

    modport master (
        output load_start, load_valid, load_data, wr_en, wr_index, wr_data, rd_index,
`ifdef LUT_PARITY_EN
        output par_inject,
        input  par_err,
`endif
        input  load_ready, busy, table_valid, wr_drop, rd_out
    );

    modport slave (
        input  load_start, load_valid, load_data, wr_en, wr_index, wr_data, rd_index,
`ifdef LUT_PARITY_EN
        input  par_inject,
        output par_err,
`endif
        output load_ready, busy, table_valid, wr_drop, rd_out
    );
endinterface

// File: rtl/lut_target_prog.sv
// Programmable signed-offset LUT: streamed boot load, single-entry patching, NRD registered
// sign-extending read channels. Optional even-parity protection under LUT_PARITY_EN.
module lut_target_prog #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned NRD    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_target_prog_if.slave     bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;
`ifdef LUT_PARITY_EN
    localparam int unsigned ENT_W = DATA_W + 1;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif

    typedef enum logic [1:0] {StEmpty, StLoad, StReady} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               busy_q, load_ready_q, table_valid_q, wr_drop_q;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [OUT_W-1:0]   rd_q [NRD];

    logic               beat, wr_ok, we;
    logic [IDX_W-1:0]   widx;
    logic [DATA_W-1:0]  wdata;
    logic [ENT_W-1:0]   wentry;

    function automatic logic [OUT_W-1:0] sext(input logic signed [DATA_W-1:0] d);
        return OUT_W'(d);
    endfunction

    // A beat coincident with load_start is dropped; writes are blocked during loading.
    assign beat  = (state_q == StLoad) && bus.load_valid && !bus.load_start;
    assign wr_ok = bus.wr_en && (state_q != StLoad) && !bus.load_start;

    always_comb begin
        we    = 1'b0;
        widx  = cnt_q;
        wdata = bus.load_data;
        if (beat) begin
            we = 1'b1;
        end else if (wr_ok) begin
            we    = 1'b1;
            widx  = bus.wr_index;
            wdata = bus.wr_data;
        end
    end

`ifdef LUT_PARITY_EN
    assign wentry = {(^wdata) ^ bus.par_inject, wdata};
`else
    assign wentry = wdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StEmpty;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            load_ready_q  <= 1'b0;
            table_valid_q <= 1'b0;
            wr_drop_q     <= 1'b0;
        end else begin
            wr_drop_q <= bus.wr_en && ((state_q == StLoad) || bus.load_start);
            if (bus.load_start) begin
                state_q       <= StLoad;
                cnt_q         <= '0;
                busy_q        <= 1'b1;
                load_ready_q  <= 1'b1;
                table_valid_q <= 1'b0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_q       <= StReady;
                    busy_q        <= 1'b0;
                    load_ready_q  <= 1'b0;
                    table_valid_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[widx] <= wentry;
        end
    end

    // Reads sample the pre-write table, so a same-cycle write is seen one read later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NRD; k++) rd_q[k] <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                rd_q[k] <= sext(mem_q[bus.rd_index[k*IDX_W +: IDX_W]][DATA_W-1:0]);
            end
        end
    end

`ifdef LUT_PARITY_EN
    logic [NRD-1:0] par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                par_err_q[k] <= ^mem_q[bus.rd_index[k*IDX_W +: IDX_W]];
            end
        end
    end

    assign bus.par_err = par_err_q;
`endif

    always_comb begin
        bus.rd_out = '0;
        for (int k = 0; k < NRD; k++) bus.rd_out[k*OUT_W +: OUT_W] = rd_q[k];
    end

    assign bus.busy        = busy_q;
    assign bus.load_ready  = load_ready_q;
    assign bus.table_valid = table_valid_q;
    assign bus.wr_drop     = wr_drop_q;
endmodule
